// File: rtl/i2c_read_bus_if.sv
// i2c_read_bus_if: pad-side and byte-side signals of the slave I2C byte receiver (ack_i only with I2C_READ_ACK_EN)
interface i2c_read_bus_if;
  logic       en;
  logic       scl_i;
  logic       sda_i;
  logic       sda_o;
  logic [7:0] data_out;
  logic       data_valid;
  logic [7:0] byte_cnt;
  logic       busy;
`ifdef I2C_READ_ACK_EN
  logic       ack_i;
  modport slave  (input en, scl_i, sda_i, ack_i, output sda_o, data_out, data_valid, byte_cnt, busy);
  modport master (output en, scl_i, sda_i, ack_i, input sda_o, data_out, data_valid, byte_cnt, busy);
`else
  modport slave  (input en, scl_i, sda_i, output sda_o, data_out, data_valid, byte_cnt, busy);
  modport master (output en, scl_i, sda_i, input sda_o, data_out, data_valid, byte_cnt, busy);
`endif
endinterface

// File: rtl/i2c_read_bus.sv
// i2c_read_bus: slave-side I2C byte receiver with ninth-clock ACK; ACK/NACK drive enabled by I2C_READ_ACK_EN
module i2c_read_bus (
  input logic          clk,
  input logic          rst_n,
  i2c_read_bus_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, ACK_WAIT, ACK_DRIVE} state_t;
  state_t     state, state_n;
  logic [1:0] scl_s, sda_s;
  logic       scl_d, scl_pos, scl_neg;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [6:0] shift_reg, shift_n;
  logic [7:0] data_out, data_n, byte_cnt, cnt_n;
  logic       data_valid, valid_n, sda_o, sda_n, ack_bit;
`ifdef I2C_READ_ACK_EN
  assign ack_bit = ~bus.ack_i;
`else
  assign ack_bit = 1'b1;
`endif
  // pad synchronizers plus registered SCL edge pulses; tracks SCL in every state so a late en sees no false edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_s   <= 2'b11;
      sda_s   <= 2'b11;
      scl_d   <= 1'b1;
      scl_pos <= 1'b0;
      scl_neg <= 1'b0;
    end else begin
      scl_s   <= {scl_s[0], bus.scl_i};
      sda_s   <= {sda_s[0], bus.sda_i};
      scl_d   <= scl_s[1];
      scl_pos <= scl_s[1] & ~scl_d;
      scl_neg <= ~scl_s[1] & scl_d;
    end
  // next-state and datapath; a low en overrides everything, including a coincident 8th rising edge
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift_reg;
    data_n    = data_out;
    valid_n   = 1'b0;
    cnt_n     = byte_cnt;
    sda_n     = sda_o;
    if (!bus.en) begin
      state_n   = IDLE;
      bit_cnt_n = 4'd0;
      sda_n     = 1'b1;
    end else
      case (state)
        IDLE: begin
          state_n   = SHIFT;
          cnt_n     = 8'd0;
          bit_cnt_n = 4'd0;
          sda_n     = 1'b1;
        end
        SHIFT:
          if (scl_pos) begin
            shift_n   = {shift_reg[5:0], sda_s[1]};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              data_n  = {shift_reg, sda_s[1]};
              valid_n = 1'b1;
              cnt_n   = byte_cnt + 8'd1;
              state_n = ACK_WAIT;
            end
          end
        ACK_WAIT:
          if (scl_neg) begin
            sda_n   = ack_bit;
            state_n = ACK_DRIVE;
          end
        ACK_DRIVE:
          if (scl_neg) begin
            sda_n     = 1'b1;
            bit_cnt_n = 4'd0;
            state_n   = SHIFT;
          end
        default: state_n = IDLE;
      endcase
  end
  // state and datapath registers; async reset releases SDA immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shift_reg  <= 7'd0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      byte_cnt   <= 8'd0;
      sda_o      <= 1'b1;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_n;
      data_out   <= data_n;
      data_valid <= valid_n;
      byte_cnt   <= cnt_n;
      sda_o      <= sda_n;
    end
  assign bus.sda_o      = sda_o;
  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.byte_cnt   = byte_cnt;
  assign bus.busy       = (bit_cnt != 4'd0) || (state == ACK_WAIT) || (state == ACK_DRIVE);
endmodule

// File: tb/tb_i2c_read_bus.sv
// tb_i2c_read_bus: directed bench for the slave I2C byte receiver
module tb_i2c_read_bus;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack = 1'b1;
  logic exp_lo;
  int   tests = 0;
  int   fails = 0;
  int   vcount = 0;
  int   ph = 20;
  always #5 clk = ~clk;
  i2c_read_bus_if bus ();
  i2c_read_bus dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
`ifdef I2C_READ_ACK_EN
  assign bus.ack_i = ack;
  assign exp_lo = ~ack;
`else
  assign exp_lo = 1'b1;
`endif
  // count every cycle the strobe is high, so a stretched pulse shows as an extra count
  always @(negedge clk)
    if (bus.data_valid === 1'b1) vcount++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      bus.scl_i = 1'b0;
      wclk(ph / 2);
      bus.sda_i = b[i];
      wclk(ph - ph / 2);
      bus.scl_i = 1'b1;
      if (i == 0) begin
        wclk(3);
        chk("valid_early", 32'(bus.data_valid), 32'd0);
        wclk(1);
        chk("valid_pulse", 32'(bus.data_valid), 32'd1);
        chk("data_at_valid", 32'(bus.data_out), 32'(b));
        wclk(ph - 4);
      end else
        wclk(ph);
    end
  endtask
  task automatic ack_clock();
    bus.scl_i = 1'b0;
    wclk(2);
    chk("ack_not_early", 32'(bus.sda_o), 32'd1);
    wclk(ph / 2 - 2);
    bus.sda_i = 1'b1;
    wclk(ph - ph / 2 - 1);
    chk("ack_low", 32'(bus.sda_o), 32'(exp_lo));
    chk("busy_ack", 32'(bus.busy), 32'd1);
    wclk(1);
    bus.scl_i = 1'b1;
    wclk(ph - 1);
    chk("ack_high", 32'(bus.sda_o), 32'(exp_lo));
    wclk(1);
    bus.scl_i = 1'b0;
    wclk(2);
    chk("ack_hold", 32'(bus.sda_o), 32'(exp_lo));
    wclk(3);
    chk("ack_release", 32'(bus.sda_o), 32'd1);
    chk("busy_after_ack", 32'(bus.busy), 32'd0);
    wclk(ph - 5);
  endtask
  task automatic send_byte(input logic [7:0] b);
    int v0;
    v0 = vcount;
    send_bits(b, 8);
    ack_clock();
    chk("one_valid", 32'(vcount - v0), 32'd1);
    chk("data_out", 32'(bus.data_out), 32'(b));
  endtask
  task automatic start_txn();
    bus.en = 1'b1;
    wclk(2);
    chk("cnt_clear", 32'(bus.byte_cnt), 32'd0);
    chk("busy_start", 32'(bus.busy), 32'd0);
  endtask
  task automatic end_txn();
    bus.en = 1'b0;
    wclk(2);
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    wclk(4);
  endtask
  initial begin
    int v0;
    bus.en = 1'b0;
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    wclk(3);
    chk("rst_sda", 32'(bus.sda_o), 32'd1);
    chk("rst_data", 32'(bus.data_out), 32'h00);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_cnt", 32'(bus.byte_cnt), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    wclk(2);
    start_txn();
    send_byte(8'hA5);
    chk("single_cnt", 32'(bus.byte_cnt), 32'd1);
    end_txn();
    start_txn();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h3C);
    chk("multi_cnt", 32'(bus.byte_cnt), 32'd3);
    end_txn();
    ack = 1'b0;
    start_txn();
    send_byte(8'h81);
    chk("nack_cnt", 32'(bus.byte_cnt), 32'd1);
    end_txn();
    ack = 1'b1;
    start_txn();
    v0 = vcount;
    send_bits(8'hF0, 5);
    bus.en = 1'b0;
    wclk(2);
    chk("abort_sda", 32'(bus.sda_o), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_novalid", 32'(vcount - v0), 32'd0);
    chk("abort_data_hold", 32'(bus.data_out), 32'h81);
    bus.scl_i = 1'b0;
    wclk(ph);
    bus.scl_i = 1'b1;
    wclk(ph);
    start_txn();
    send_byte(8'h12);
    chk("reenable_cnt", 32'(bus.byte_cnt), 32'd1);
    end_txn();
    start_txn();
    send_bits(8'hC3, 8);
    bus.scl_i = 1'b0;
    wclk(6);
    chk("pre_reset_sda", 32'(bus.sda_o), 32'(exp_lo));
    rst_n = 1'b0;
    #1;
    chk("arst_sda", 32'(bus.sda_o), 32'd1);
    chk("arst_data", 32'(bus.data_out), 32'h00);
    chk("arst_valid", 32'(bus.data_valid), 32'd0);
    chk("arst_cnt", 32'(bus.byte_cnt), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    bus.en = 1'b0;
    bus.scl_i = 1'b1;
    bus.sda_i = 1'b1;
    wclk(2);
    rst_n = 1'b1;
    wclk(2);
    start_txn();
    send_byte(8'h5A);
    chk("post_reset_cnt", 32'(bus.byte_cnt), 32'd1);
    end_txn();
    ph = 6;
    start_txn();
    for (int k = 0; k < 256; k++) begin
      send_byte(8'(k));
      if (k == 254) chk("cnt_255", 32'(bus.byte_cnt), 32'd255);
    end
    chk("wrap_cnt_0", 32'(bus.byte_cnt), 32'd0);
    send_byte(8'h77);
    chk("wrap_cnt_1", 32'(bus.byte_cnt), 32'd1);
    end_txn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
